// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared constants and FSM state type for the JTAG DR controller
package jtag_pkg;

  localparam int         DR_BITS_DEF = 32;
  localparam logic [7:0] IR_ER1      = 8'h32;
  localparam logic [7:0] IR_ER2      = 8'h38;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } dr_state_e;

endpackage

// File: rtl/jtag_dr_ctl_if.sv
// rtl/jtag_dr_ctl_if.sv - SoC debug-register port between the DR controller and its consumer
interface jtag_dr_ctl_if #(
  parameter int DR_BITS = 32
);
  logic [DR_BITS-1:0] dbgreg_out;
  logic [DR_BITS-1:0] dbgreg_in;
  logic               dbgreg_sel;
  logic               dbgreg_strobe;
  logic               short_err;

  modport master (
    input  dbgreg_out,
    output dbgreg_in,
    output dbgreg_sel,
    output dbgreg_strobe,
    output short_err
  );

  modport slave (
    output dbgreg_out,
    input  dbgreg_in,
    input  dbgreg_sel,
    input  dbgreg_strobe,
    input  short_err
  );
endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer for a data bus plus one edge-detected strobe input
module sync_edge #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             edge_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             rise_o
);
  // Edge input rides in the top bit so every input sees identical latency.
  logic [STAGES-1:0][WIDTH:0] chain_q;
  logic                       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], edge_i, d_i};
      prev_q  <= chain_q[STAGES-1][WIDTH];
    end
  end

  assign q_o    = chain_q[STAGES-1][WIDTH-1:0];
  assign rise_o = chain_q[STAGES-1][WIDTH] & ~prev_q;

endmodule

// File: rtl/jtag_dr_ctl.sv
// rtl/jtag_dr_ctl.sv - JTAG ER1/ER2 data-register capture/shift/update in the SoC clock domain
module jtag_dr_ctl
  import jtag_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DR_BITS     = DR_BITS_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          jtck,
  input  logic          jtdi,
  input  logic          jshift,
  input  logic          jupdate,
  input  logic          jce1,
  input  logic          jce2,
  input  logic          jrstn,
  output logic          jtdo,
  jtag_dr_ctl_if.master dbg
);
  localparam logic [5:0] CNT_MAX = 6'd63;

  logic [5:0] tap_s;
  logic       rise;
  logic       s_jtdi, s_jshift, s_jupdate, s_jce1, s_jce2, s_jrstn;
  logic       capture;

  dr_state_e          state_q, state_d;
  logic [DR_BITS-1:0] shreg_q, shreg_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               sel_q, sel_d;
  logic               shift_q, shift_d;
  logic [DR_BITS-1:0] din_q, din_d;
  logic               dsel_q, dsel_d;
  logic               strobe_q, strobe_d;
  logic               err_q, err_d;

  sync_edge #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (6)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rstn),
    .edge_i (jtck),
    .d_i    ({jrstn, jce2, jce1, jupdate, jshift, jtdi}),
    .q_o    (tap_s),
    .rise_o (rise)
  );

  assign {s_jrstn, s_jce2, s_jce1, s_jupdate, s_jshift, s_jtdi} = tap_s;
  assign capture = (s_jce1 | s_jce2) & ~s_jshift;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      shift_q  <= 1'b0;
      din_q    <= '0;
      dsel_q   <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shift_q  <= shift_d;
      din_q    <= din_d;
      dsel_q   <= dsel_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    shift_d  = shift_q;
    din_d    = din_q;
    dsel_d   = dsel_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    // TAP test-logic reset clears the shift path but leaves the last accepted word alone.
    if (!s_jrstn) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      sel_d   = 1'b0;
      shift_d = 1'b0;
    end else if (rise) begin
      shift_d = s_jshift;
      case (state_q)
        ST_IDLE: begin
          if (capture && !s_jupdate) begin
            shreg_d = dbg.dbgreg_out;
            sel_d   = s_jce2;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (s_jupdate) begin
            if (int'(cnt_q) >= DR_BITS) begin
              din_d    = shreg_q;
              dsel_d   = sel_q;
              strobe_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = ST_IDLE;
          end else if (capture) begin
            shreg_d = dbg.dbgreg_out;
            sel_d   = s_jce2;
            cnt_d   = '0;
          end else if (shift_q) begin
            // shift_q reflects Shift-DR at the previous TCK edge, so the Exit1 edge still shifts.
            shreg_d = {s_jtdi, shreg_q[DR_BITS-1:1]};
            cnt_d   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 6'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign jtdo              = shreg_q[0];
  assign dbg.dbgreg_in     = din_q;
  assign dbg.dbgreg_sel    = dsel_q;
  assign dbg.dbgreg_strobe = strobe_q;
  assign dbg.short_err     = err_q;

endmodule

// File: tb/tb_jtag_dr_ctl.sv
// tb/tb_jtag_dr_ctl.sv - randomized bench for jtag_dr_ctl against a per-TCK-edge reference model
module tb_jtag_dr_ctl;
  import jtag_pkg::*;

  localparam int HALF_MIN = 104;
  localparam int HALF_STD = 150;

  logic clk     = 1'b0;
  logic rstn    = 1'b0;
  logic jtck    = 1'b0;
  logic jtdi    = 1'b0;
  logic jshift  = 1'b0;
  logic jupdate = 1'b0;
  logic jce1    = 1'b0;
  logic jce2    = 1'b0;
  logic jrstn   = 1'b1;
  logic jtdo;

  jtag_dr_ctl_if #(.DR_BITS(32)) dbg ();

  jtag_dr_ctl #(
    .SYNC_STAGES (2),
    .DR_BITS     (32)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .jtck    (jtck),
    .jtdi    (jtdi),
    .jshift  (jshift),
    .jupdate (jupdate),
    .jce1    (jce1),
    .jce2    (jce2),
    .jrstn   (jrstn),
    .jtdo    (jtdo),
    .dbg     (dbg)
  );

  always #10 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int stb_total = 0;
  int err_total = 0;

  always @(negedge clk) begin
    if (dbg.dbgreg_strobe) stb_total++;
    if (dbg.short_err) err_total++;
  end

  // Reference model: one step per TCK rising edge.
  bit          m_busy = 1'b0;
  bit          m_shq  = 1'b0;
  bit          m_sel  = 1'b0;
  bit          m_dsel = 1'b0;
  logic [31:0] m_sh   = '0;
  logic [31:0] m_din  = '0;
  int          m_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tap_cycle(input bit c1, input bit c2, input bit sh, input bit up,
                           input bit tdi, input bit trst, input int half);
    int s0, e0;
    bit exp_stb, exp_err;
    exp_stb = 1'b0;
    exp_err = 1'b0;
    jtck = 1'b0;
    jce1 = c1; jce2 = c2; jshift = sh; jupdate = up; jtdi = tdi; jrstn = trst;
    #(half);
    s0 = stb_total;
    e0 = err_total;
    jtck = 1'b1;
    if (!trst) begin
      m_busy = 1'b0; m_sh = '0; m_cnt = 0; m_sel = 1'b0; m_shq = 1'b0;
    end else begin
      if (up) begin
        if (m_busy) begin
          if (m_cnt >= 32) begin
            m_din = m_sh; m_dsel = m_sel; exp_stb = 1'b1;
          end else begin
            exp_err = 1'b1;
          end
          m_busy = 1'b0;
        end
      end else if ((c1 || c2) && !sh) begin
        m_sh = dbg.dbgreg_out; m_sel = c2; m_cnt = 0; m_busy = 1'b1;
      end else if (m_busy && m_shq) begin
        m_sh  = (m_sh >> 1) | (32'(tdi) << 31);
        m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
      end
      m_shq = sh;
    end
    #(half);
    @(negedge clk);
    #1;
    check_eq("strobe_count", 32'(stb_total - s0), 32'(exp_stb));
    check_eq("short_err_count", 32'(err_total - e0), 32'(exp_err));
    check_eq("jtdo", 32'(jtdo), 32'(m_sh[0]));
    check_eq("dbgreg_in", dbg.dbgreg_in, m_din);
    check_eq("dbgreg_sel", 32'(dbg.dbgreg_sel), 32'(m_dsel));
    jtck = 1'b0;
  endtask

  // One full DR scan: Idle, Capture, n Shift-DR edges, Exit1, pauses, Update.
  // rd collects jtdo as the captured word leaves LSB first.
  task automatic xfer(input bit er2, input logic [31:0] dout, input logic [63:0] data,
                      input int n, input int pauses, input int trst_at, input int recap_at,
                      input int half, output logic [31:0] rd);
    bit tdi;
    dbg.dbgreg_out = dout;
    rd = '0;
    tap_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, half);
    tap_cycle(!er2, er2, 1'b0, 1'b0, 1'b0, 1'b1, half);
    rd[0] = jtdo;
    for (int j = 1; j <= n; j++) begin
      tdi = (j >= 2) ? data[j-2] : 1'($urandom);
      tap_cycle(!er2, er2, (j != recap_at), 1'b0, tdi, (j != trst_at), half);
      if (j >= 2 && j <= 32) rd[j-1] = jtdo;
    end
    tap_cycle(1'b0, 1'b0, 1'b0, 1'b0, (n > 0) ? data[n-1] : 1'b0, 1'b1, half);
    for (int p = 0; p < pauses; p++)
      tap_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'b1, half);
    tap_cycle(!er2 && 1'($urandom), er2 && 1'($urandom), 1'b0, 1'b1, 1'($urandom), 1'b1, half);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] w;
    int s0, e0;

    dbg.dbgreg_out = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_dbgreg_in", dbg.dbgreg_in, 32'h0);
    check_eq("rst_dbgreg_sel", 32'(dbg.dbgreg_sel), 32'h0);
    check_eq("rst_strobe", 32'(dbg.dbgreg_strobe), 32'h0);
    check_eq("rst_short_err", 32'(dbg.short_err), 32'h0);
    check_eq("rst_jtdo", 32'(jtdo), 32'h0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    s0 = stb_total; e0 = err_total;
    xfer(1'b0, 32'h5555_AAAA, 64'hDEADBEEF, 32, 0, 0, 0, HALF_STD, rd);
    check_eq("er1_data", dbg.dbgreg_in, 32'hDEADBEEF);
    check_eq("er1_sel", 32'(dbg.dbgreg_sel), 32'h0);
    check_eq("er1_strobes", 32'(stb_total - s0), 32'd1);
    check_eq("er1_errs", 32'(err_total - e0), 32'd0);

    s0 = stb_total; e0 = err_total;
    xfer(1'b0, $urandom, {$urandom, $urandom}, 20, 0, 0, 0, HALF_STD, rd);
    check_eq("short_errs", 32'(err_total - e0), 32'd1);
    check_eq("short_strobes", 32'(stb_total - s0), 32'd0);
    check_eq("short_hold", dbg.dbgreg_in, 32'hDEADBEEF);

    s0 = stb_total;
    xfer(1'b1, 32'h12345678, 64'h0, 32, 1, 0, 0, HALF_STD, rd);
    check_eq("er2_readback", rd, 32'h12345678);
    check_eq("er2_data", dbg.dbgreg_in, 32'h0);
    check_eq("er2_sel", 32'(dbg.dbgreg_sel), 32'h1);
    check_eq("er2_strobes", 32'(stb_total - s0), 32'd1);

    xfer(1'b0, $urandom, 64'h0000_00A5_A5A5_A5FF, 40, 0, 0, 0, HALF_STD, rd);
    check_eq("long_data", dbg.dbgreg_in, 32'hA5A5A5A5);

    s0 = stb_total; e0 = err_total;
    xfer(1'b0, $urandom, {$urandom, $urandom}, 32, 0, 10, 0, HALF_STD, rd);
    check_eq("jrst_strobes", 32'(stb_total - s0), 32'd0);
    check_eq("jrst_errs", 32'(err_total - e0), 32'd0);
    check_eq("jrst_hold", dbg.dbgreg_in, 32'hA5A5A5A5);
    xfer(1'b0, $urandom, 64'h0BADF00D, 32, 0, 0, 0, HALF_STD, rd);
    check_eq("after_jrst_data", dbg.dbgreg_in, 32'h0BADF00D);

    dbg.dbgreg_out = 32'hFFFF_FFFF;
    tap_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, HALF_STD);
    tap_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, HALF_STD);
    for (int j = 0; j < 5; j++) tap_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, HALF_STD);
    rstn = 1'b0;
    #1;
    check_eq("rstn_mid_dbgreg_in", dbg.dbgreg_in, 32'h0);
    check_eq("rstn_mid_sel", 32'(dbg.dbgreg_sel), 32'h0);
    check_eq("rstn_mid_jtdo", 32'(jtdo), 32'h0);
    check_eq("rstn_mid_strobe", 32'(dbg.dbgreg_strobe), 32'h0);
    m_busy = 1'b0; m_shq = 1'b0; m_sel = 1'b0; m_dsel = 1'b0;
    m_sh = '0; m_din = '0; m_cnt = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      xfer(1'(k), $urandom, {32'h0, w}, 32, 0, 0, 0, HALF_MIN, rd);
      check_eq("b2b_data", dbg.dbgreg_in, w);
      check_eq("b2b_sel", 32'(dbg.dbgreg_sel), 32'(k & 1));
    end

    for (int t = 0; t < 30; t++) begin
      int n, tr, rc;
      n  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 45) : $urandom_range(30, 45);
      tr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 45) : 0;
      rc = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 45) : 0;
      xfer(1'($urandom), $urandom, {$urandom, $urandom}, n, $urandom_range(0, 2),
           tr, rc, $urandom_range(HALF_MIN, 160), rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
